append_timestamp: RTL and testbench

Ingress stage placed directly upstream of separate_timestamp. It captures a free-running timestamp on the first beat of each Ethernet frame. It passes the frame through and appends the captured timestamp as a footer, so the output carries [Ethernet Frame]/[Timestamp]. In parallel, it emits the frame's byte length (footer excluded) on a side AXI4-Stream, which is the frame-length input separate_timestamp consumes.

---
 rtl/tsn_stream_pkg.sv | 17 +
 rtl/append_timestamp_if.sv | 10 +
 rtl/timestamp_footer_serializer.sv | 38 +++
 rtl/append_timestamp.sv | 104 ++++++++++
 tb/tb_append_timestamp.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tsn_stream_pkg.sv
// Constants and FSM encoding shared by the timestamp append/separate stream stages.
package tsn_stream_pkg;
    localparam int DEF_DATA_WIDTH         = 8;
    localparam int DEF_FRAME_LENGTH_WIDTH = 16;
    localparam int DEF_TIMESTAMP_WIDTH    = 72;
    localparam int FOOTER_BEATS           = DEF_TIMESTAMP_WIDTH / DEF_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FRAME  = 2'd1,
        ST_FOOTER = 2'd2
    } tsn_state_e;

    function automatic int idx_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction
endpackage

// File: rtl/append_timestamp_if.sv
// AXI4-Stream bundle used for the frame, footer and frame-length streams.
interface append_timestamp_if #(parameter int W = 8);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/timestamp_footer_serializer.sv
// Holds a captured timestamp and emits it MSB-first, one DATA_WIDTH beat per advance.
module timestamp_footer_serializer
    import tsn_stream_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int TIMESTAMP_WIDTH = DEF_TIMESTAMP_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [TIMESTAMP_WIDTH-1:0] ts,
    input  logic                       advance,
    output logic [DATA_WIDTH-1:0]      data,
    output logic                       last
);
    localparam int BEATS = TIMESTAMP_WIDTH / DATA_WIDTH;
    localparam int IW    = idx_width(BEATS);

    logic [TIMESTAMP_WIDTH-1:0] sh;
    logic [IW-1:0]              idx;

    // Shifting left keeps the current beat in a fixed MSB slice, so no wide mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh  <= '0;
            idx <= '0;
        end else if (load) begin
            sh  <= ts;
            idx <= '0;
        end else if (advance) begin
            sh  <= sh << DATA_WIDTH;
            idx <= last ? '0 : idx + 1'b1;
        end
    end

    assign data = sh[TIMESTAMP_WIDTH-1 -: DATA_WIDTH];
    assign last = (idx == IW'(BEATS - 1));
endmodule

// File: rtl/append_timestamp.sv
// Passes an Ethernet frame through, appends the SOF timestamp as a footer and
// reports the payload byte length on a side stream.
module append_timestamp
    import tsn_stream_pkg::*;
#(
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int FRAME_LENGTH_WIDTH = DEF_FRAME_LENGTH_WIDTH,
    parameter int TIMESTAMP_WIDTH    = DEF_TIMESTAMP_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
    append_timestamp_if.slave          s_axis,
    append_timestamp_if.master         m_axis,
    append_timestamp_if.master         m_axis_frame_length
);
    localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int SUM_W          = FRAME_LENGTH_WIDTH + 1;

    tsn_state_e                    state;
    logic [FRAME_LENGTH_WIDTH-1:0] byte_cnt;
    logic [FRAME_LENGTH_WIDTH-1:0] len_q;
    logic                          len_valid;
    logic [SUM_W-1:0]              sum;
    logic [FRAME_LENGTH_WIDTH-1:0] cnt_next;
    logic                          gate, in_footer, pay_hs, foot_hs, sof;
    logic [DATA_WIDTH-1:0]         ser_data;
    logic                          ser_last;

    always_comb begin
        sum      = {1'b0, byte_cnt} + SUM_W'(BYTES_PER_BEAT);
        cnt_next = sum[SUM_W-1] ? '1 : sum[FRAME_LENGTH_WIDTH-1:0];
    end

    // The last payload beat waits until the previous length has been taken.
    always_comb begin
        in_footer     = (state == ST_FOOTER);
        gate          = ~(s_axis.tlast & len_valid);
        m_axis.tdata  = s_axis.tdata;
        m_axis.tvalid = 1'b0;
        m_axis.tlast  = 1'b0;
        s_axis.tready = 1'b0;
        if (!rst) begin
            if (in_footer) begin
                m_axis.tdata  = ser_data;
                m_axis.tvalid = 1'b1;
                m_axis.tlast  = ser_last;
            end else begin
                m_axis.tvalid = s_axis.tvalid & gate;
                s_axis.tready = m_axis.tready & gate;
            end
        end
    end

    assign pay_hs  = s_axis.tvalid & s_axis.tready;
    assign foot_hs = in_footer & m_axis.tready & ~rst;
    assign sof     = pay_hs & (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            byte_cnt  <= '0;
            len_q     <= '0;
            len_valid <= 1'b0;
        end else begin
            if (len_valid && m_axis_frame_length.tready)
                len_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_FRAME: begin
                    if (pay_hs) begin
                        if (s_axis.tlast) begin
                            len_q     <= cnt_next;
                            len_valid <= 1'b1;
                            byte_cnt  <= '0;
                            state     <= ST_FOOTER;
                        end else begin
                            byte_cnt <= cnt_next;
                            state    <= ST_FRAME;
                        end
                    end
                end
                ST_FOOTER: if (foot_hs && ser_last) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    timestamp_footer_serializer #(
        .DATA_WIDTH     (DATA_WIDTH),
        .TIMESTAMP_WIDTH(TIMESTAMP_WIDTH)
    ) u_ser (
        .clk    (clk),
        .rst    (rst),
        .load   (sof),
        .ts     (timestamp),
        .advance(foot_hs),
        .data   (ser_data),
        .last   (ser_last)
    );

    assign m_axis_frame_length.tdata  = len_q;
    assign m_axis_frame_length.tvalid = len_valid;
    assign m_axis_frame_length.tlast  = 1'b1;
endmodule

// File: tb/tb_append_timestamp.sv
// Directed and randomised checks of append_timestamp against a queue-based model.
module tb_append_timestamp;
    localparam int DW  = 8;
    localparam int FLW = 16;
    localparam int TW  = 72;
    localparam int FB  = TW / DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [TW-1:0] timestamp = '0;
    logic [TW-1:0] ts_set = '0;
    bit            ts_run = 1'b0;
    int            rdy_prob = 100;
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;

    logic [8:0] out_q[$];
    logic [8:0] exp_q[$];
    int         out_cyc_q[$];
    int         len_q[$];
    int         exp_len_q[$];
    int         op = 0, ep = 0, lp = 0, elp = 0;

    append_timestamp_if #(.W(DW))  s_if ();
    append_timestamp_if #(.W(DW))  m_if ();
    append_timestamp_if #(.W(FLW)) fl_if ();

    append_timestamp #(
        .DATA_WIDTH(DW), .FRAME_LENGTH_WIDTH(FLW), .TIMESTAMP_WIDTH(TW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .timestamp          (timestamp),
        .s_axis             (s_if),
        .m_axis             (m_if),
        .m_axis_frame_length(fl_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk); #1;
        timestamp = ts_run ? timestamp + 72'd7 : ts_set;
    end

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_if.tready = ($urandom_range(99) < rdy_prob);
        end
    end

    // Values seen at the falling edge are exactly what the DUT samples next rising edge.
    initial forever begin
        @(negedge clk);
        if (m_if.tvalid && m_if.tready) begin
            out_q.push_back({m_if.tlast, m_if.tdata});
            out_cyc_q.push_back(cyc);
        end
        if (fl_if.tvalid && fl_if.tready) len_q.push_back(int'(fl_if.tdata));
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input int n, input int seed, input int vprob);
        int            i = 0;
        int            guard = 0;
        bit            acc = 1'b0;
        logic [TW-1:0] ts_cap = '0;
        s_if.tvalid = 1'b0;
        while (i < n && guard < 50000) begin
            if (acc) s_if.tvalid = 1'b0;
            if (!s_if.tvalid) s_if.tvalid = ($urandom_range(99) < vprob);
            s_if.tdata = 8'(seed + i);
            s_if.tlast = (i == n - 1);
            @(negedge clk);
            acc = s_if.tvalid && s_if.tready;
            if (acc) begin
                if (i == 0) ts_cap = timestamp;
                exp_q.push_back({1'b0, s_if.tdata});
                i++;
            end
            @(posedge clk); #1;
            guard++;
        end
        check("send_done", i, n);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        for (int k = 0; k < FB; k++) exp_q.push_back({(k == FB - 1), ts_cap[TW-1-8*k -: 8]});
        exp_len_q.push_back(n);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((out_q.size() - op < exp_q.size() - ep ||
                len_q.size() - lp < exp_len_q.size() - elp) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, " drain_cycles_left"}, (n < 20000), 1);
    endtask

    task automatic check_stream(input string name);
        int bad = 0;
        int first = -1;
        check({name, " beats"}, out_q.size() - op, exp_q.size() - ep);
        for (int i = 0; op + i < out_q.size() && ep + i < exp_q.size(); i++)
            if (out_q[op+i] !== exp_q[ep+i]) begin
                bad++;
                if (first < 0) first = i;
            end
        if (bad != 0) $display("  %s first differing beat %0d", name, first);
        check({name, " data_errors"}, bad, 0);
        check({name, " lengths"}, len_q.size() - lp, exp_len_q.size() - elp);
        for (int i = 0; lp + i < len_q.size() && elp + i < exp_len_q.size(); i++)
            check({name, " len"}, len_q[lp+i], exp_len_q[elp+i]);
        op = out_q.size(); ep = exp_q.size(); lp = len_q.size(); elp = exp_len_q.size();
    endtask

    function automatic logic [8:0] beat_at(input int idx);
        return (idx < out_q.size()) ? out_q[idx] : 9'bx;
    endfunction

    typedef struct {
        int          nbytes;
        logic [71:0] ts;
        int          exp_len;
        int          exp_beats;
        logic [7:0]  exp_foot_first;
        logic [7:0]  exp_foot_last;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int base;
        vecs[0] = '{64, 72'hABFEDCBA9876543210, 64, 73, 8'hAB, 8'h10};
        vecs[1] = '{1,  72'h0123456789ABCDEF55, 1,  10, 8'h01, 8'h55};
        vecs[2] = '{2,  72'hFF00FF00FF00FF00FF, 2,  11, 8'hFF, 8'hFF};
        vecs[3] = '{17, 72'h000000000000000001, 17, 26, 8'h00, 8'h01};

        s_if.tvalid = 1'b1; s_if.tdata = 8'h5A; s_if.tlast = 1'b1;
        fl_if.tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst s_tready", s_if.tready, 0);
        check("rst m_tvalid", m_if.tvalid, 0);
        check("rst m_tlast", m_if.tlast, 0);
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst fl_tvalid", fl_if.tvalid, 0);
        check("rst fl_tdata", fl_if.tdata, 0);
        check("rst m_tvalid idle", m_if.tvalid, 0);

        for (int v = 0; v < 4; v++) begin
            ts_run = 1'b0;
            ts_set = vecs[v].ts;
            @(posedge clk); #1;
            base = out_q.size();
            send_frame(vecs[v].nbytes, v * 16, 100);
            wait_drain("vec");
            check("vec beat_count", out_q.size() - base, vecs[v].exp_beats);
            check("vec first_footer", beat_at(base + vecs[v].nbytes), {1'b0, vecs[v].exp_foot_first});
            check("vec last_footer", beat_at(base + vecs[v].exp_beats - 1), {1'b1, vecs[v].exp_foot_last});
            if (len_q.size() > lp) check("vec length", len_q[lp], vecs[v].exp_len);
            else check("vec length_present", len_q.size() - lp, 1);
            check_stream("vec");
        end

        // Back-to-back: only footer beats separate consecutive frames.
        ts_run = 1'b1;
        base = out_q.size();
        for (int f = 0; f < 3; f++) send_frame(10, 8'h30 + f * 10, 100);
        wait_drain("b2b");
        if (out_q.size() >= base + 57)
            check("b2b span", out_cyc_q[base+56] - out_cyc_q[base] + 1, 57);
        else
            check("b2b beats_present", out_q.size() - base, 57);
        check_stream("b2b");

        // Frame 1 length held unconsumed stalls frame 2's last beat.
        fl_if.tready = 1'b0;
        send_frame(5, 8'h10, 100);
        fork
            send_frame(4, 8'h20, 100);
            begin
                repeat (30) @(posedge clk);
                @(negedge clk);
                check("hold s_tready", s_if.tready, 0);
                check("hold last_pending", s_if.tvalid && s_if.tlast, 1);
                check("hold fl_tvalid", fl_if.tvalid, 1);
                check("hold fl_tdata", fl_if.tdata, 5);
                @(posedge clk); #1;
                fl_if.tready = 1'b1;
            end
        join
        wait_drain("lenhold");
        check_stream("lenhold");

        // One-cycle reset in the middle of a payload.
        for (int i = 0; i < 5; i++) begin
            s_if.tvalid = 1'b1; s_if.tdata = 8'(8'h50 + i); s_if.tlast = 1'b0;
            @(negedge clk);
            if (s_if.tvalid && s_if.tready) exp_q.push_back({1'b0, s_if.tdata});
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst s_tready", s_if.tready, 0);
        check("midrst m_tvalid", m_if.tvalid, 0);
        check("midrst m_tlast", m_if.tlast, 0);
        check("midrst fl_tvalid", fl_if.tvalid, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst m_tvalid after", m_if.tvalid, 0);
        check("midrst fl_tdata", fl_if.tdata, 0);
        send_frame(7, 8'h70, 100);
        wait_drain("midrst");
        check_stream("midrst");

        // Randomised handshakes, boundary lengths first.
        rdy_prob = 80;
        for (int f = 0; f < 24; f++) begin
            int n;
            n = (f == 0) ? 60 : (f == 1) ? 1518 : $urandom_range(60, 1518);
            send_frame(n, f * 3, 85);
        end
        wait_drain("rand");
        check_stream("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
